sr_register_bank: RTL and testbench

Parametrised, clocked bank of WIDTH independent SR storage cells. It is the synchronous, multi-channel successor to the single asynchronous SR latch. Adds:
- a run-time selectable resolution for the S=R=1 case (hold / set-dominant / reset-dominant / toggle);
- a global enable;
- per-channel conflict flags;
- a saturating conflict-event counter with sticky error flag.

It sits in the control/status path as a bank of event flags set and cleared by independent sources.

---
 rtl/sr_register_bank.sv | 102 ++++++++++
 tb/tb_sr_register_bank.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_register_bank.sv
// sr_register_bank: clocked bank of WIDTH independent SR flag cells.
// The S=R=1 case is resolved at run time by MODE (hold/set/reset/toggle).
// Conflicts while enabled are flagged per channel for one cycle, and they
// feed a saturating event counter and a sticky error flag.
// Every output is registered, so no input reaches an output combinationally.
module sr_register_bank #(
  parameter int               WIDTH   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic [WIDTH-1:0] CONFLICT,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SET   = 2'b01;
  localparam logic [1:0] MODE_RESET = 2'b10;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] qn_reg;
  logic [WIDTH-1:0] conflict_reg;
  logic             sticky_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] both_next;
  logic             ev;
  logic             cnt_sat;

  // Channels that request set and reset at the same time. Requests made
  // while the bank is disabled are not conflicts at all.
  assign both_next = EN ? (S & R) : {WIDTH{1'b0}};

  // One event per cycle, however many channels collide in it.
  assign ev      = |both_next;
  assign cnt_sat = &cnt_reg;

  // Per-channel next state. MODE only matters when S and R are both high.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic both_val;
      assign both_val = (MODE == MODE_HOLD)  ? q_reg[gi] :
                        (MODE == MODE_SET)   ? 1'b1 :
                        (MODE == MODE_RESET) ? 1'b0 :
                                               ~q_reg[gi];
      assign q_next[gi] = !EN                  ? q_reg[gi] :
                          (S[gi] && R[gi])     ? both_val :
                          S[gi]                ? 1'b1 :
                          R[gi]                ? 1'b0 :
                                                 q_reg[gi];
    end
  endgenerate

  // Channel state, its complement and the one-cycle conflict flags.
  // QN is loaded from the same next value as Q so the two never diverge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg        <= RST_VAL;
      qn_reg       <= ~RST_VAL;
      conflict_reg <= {WIDTH{1'b0}};
    end else begin
      q_reg        <= q_next;
      qn_reg       <= ~q_next;
      conflict_reg <= both_next;
    end
  end

  // Error counter and sticky flag. A clear that lands on the same edge as
  // an event restarts the count at 1 so that event is still recorded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg    <= {CNT_W{1'b0}};
      sticky_reg <= 1'b0;
    end else if (CLR_ERR && ev) begin
      cnt_reg    <= {{(CNT_W-1){1'b0}}, 1'b1};
      sticky_reg <= 1'b1;
    end else if (CLR_ERR) begin
      cnt_reg    <= {CNT_W{1'b0}};
      sticky_reg <= 1'b0;
    end else if (ev) begin
      cnt_reg    <= cnt_sat ? cnt_reg : cnt_reg + 1'b1;
      sticky_reg <= 1'b1;
    end
  end

  assign Q          = q_reg;
  assign QN         = qn_reg;
  assign CONFLICT   = conflict_reg;
  assign ERR_STICKY = sticky_reg;
  assign ERR_CNT    = cnt_reg;

endmodule

// File: tb/tb_sr_register_bank.sv
// Directed bench for sr_register_bank (WIDTH=4, CNT_W=3, RST_VAL=1010).
// Inputs change 1 time unit after a rising edge; outputs are checked at
// that same point, after the edge that consumed the inputs.
module tb_sr_register_bank;

  localparam int               WIDTH   = 4;
  localparam int               CNT_W   = 3;
  localparam logic [WIDTH-1:0] RST_VAL = 4'b1010;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] conflict;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  sr_register_bank #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .RST_VAL(RST_VAL)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .MODE      (mode),
    .S         (s),
    .R         (r),
    .CLR_ERR   (clr_err),
    .Q         (q),
    .QN        (qn),
    .CONFLICT  (conflict),
    .ERR_STICKY(err_sticky),
    .ERR_CNT   (err_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and report what the DUT now shows.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    $display("[TB] cyc %0d rst=%b en=%b mode=%b s=%b r=%b clr=%b -> q=%b qn=%b conf=%b sticky=%b cnt=%0d",
             cycle, rst, en, mode, s, r, clr_err, q, qn, conflict, err_sticky, err_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b11; s = 4'b1111; r = 4'b1111; clr_err = 1'b0;
    step();
    rst = 1'b0; en = 1'b0; s = 4'b0000; r = 4'b0000; mode = 2'b00;
    tests_run++;
    if (q !== 4'b1010) begin tests_failed++; $display("FAIL reset_q: got %b want 1010", q); end
    tests_run++;
    if (qn !== 4'b0101) begin tests_failed++; $display("FAIL reset_qn: got %b want 0101", qn); end
    tests_run++;
    if (conflict !== 4'b0000) begin tests_failed++; $display("FAIL reset_conflict: got %b want 0000", conflict); end
    tests_run++;
    if (err_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", err_cnt); end
    tests_run++;
    if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
  endtask

  task automatic test_basic();
    en = 1'b1; s = 4'b0001; r = 4'b1000;
    step();
    tests_run++;
    if (q !== 4'b0011) begin tests_failed++; $display("FAIL basic_q: got %b want 0011", q); end
    tests_run++;
    if (qn !== 4'b1100) begin tests_failed++; $display("FAIL basic_qn: got %b want 1100", qn); end
    tests_run++;
    if (conflict !== 4'b0000) begin tests_failed++; $display("FAIL basic_conflict: got %b want 0000", conflict); end
  endtask

  task automatic test_mode_sweep();
    logic [1:0]       modes [6];
    logic [WIDTH-1:0] exp_q [6];
    modes = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    exp_q = '{4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0011};
    // Clear channel 0 first so the sweep starts from Q[0]=0.
    en = 1'b1; s = 4'b0000; r = 4'b0001;
    step();
    tests_run++;
    if (q !== 4'b0010) begin tests_failed++; $display("FAIL sweep_pre_q: got %b want 0010", q); end
    s = 4'b0001; r = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      mode = modes[i];
      step();
      tests_run++;
      if (q !== exp_q[i]) begin tests_failed++; $display("FAIL sweep_q[%0d]: got %b want %b", i, q, exp_q[i]); end
      tests_run++;
      if (conflict !== 4'b0001) begin tests_failed++; $display("FAIL sweep_conflict[%0d]: got %b want 0001", i, conflict); end
      tests_run++;
      if (err_cnt !== 3'(i + 1)) begin tests_failed++; $display("FAIL sweep_cnt[%0d]: got %0d want %0d", i, err_cnt, i + 1); end
    end
    tests_run++;
    if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL sweep_sticky: got %b want 1", err_sticky); end
  endtask

  task automatic test_enable_gating();
    en = 1'b0; mode = 2'b01; s = 4'b1111; r = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (q !== 4'b0011) begin tests_failed++; $display("FAIL gate_q[%0d]: got %b want 0011", i, q); end
      tests_run++;
      if (conflict !== 4'b0000) begin tests_failed++; $display("FAIL gate_conflict[%0d]: got %b want 0000", i, conflict); end
      tests_run++;
      if (err_cnt !== 3'd6) begin tests_failed++; $display("FAIL gate_cnt[%0d]: got %0d want 6", i, err_cnt); end
    end
    // Clear with no event, then show a disabled collision leaves the flag clear.
    s = 4'b0000; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    tests_run++;
    if (err_cnt !== 3'd0 || err_sticky !== 1'b0) begin
      tests_failed++; $display("FAIL gate_clear: got cnt=%0d sticky=%b want cnt=0 sticky=0", err_cnt, err_sticky);
    end
    s = 4'b1111; r = 4'b1111; mode = 2'b11;
    step();
    tests_run++;
    if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL gate_sticky: got %b want 0", err_sticky); end
    tests_run++;
    if (err_cnt !== 3'd0) begin tests_failed++; $display("FAIL gate_cnt_dis: got %0d want 0", err_cnt); end
    tests_run++;
    if (q !== 4'b0011 || conflict !== 4'b0000) begin
      tests_failed++; $display("FAIL gate_toggle: got q=%b conf=%b want q=0011 conf=0000", q, conflict);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    en = 1'b1; mode = 2'b00; s = 4'b0011; r = 4'b0011;
    for (int i = 1; i <= 10; i++) begin
      exp_cnt = (i > 7) ? 7 : i;
      step();
      tests_run++;
      if (err_cnt !== 3'(exp_cnt)) begin tests_failed++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_cnt); end
      tests_run++;
      if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL sat_sticky[%0d]: got %b want 1", i, err_sticky); end
    end
    tests_run++;
    if (q !== 4'b0011 || conflict !== 4'b0011) begin
      tests_failed++; $display("FAIL sat_q: got q=%b conf=%b want q=0011 conf=0011", q, conflict);
    end
  endtask

  task automatic test_clear_collision();
    // Bring the counter to exactly 5.
    en = 1'b1; mode = 2'b00; s = 4'b0000; r = 4'b0000; clr_err = 1'b1;
    step();
    clr_err = 1'b0; s = 4'b0001; r = 4'b0001;
    repeat (5) step();
    tests_run++;
    if (err_cnt !== 3'd5) begin tests_failed++; $display("FAIL clr_pre_cnt: got %0d want 5", err_cnt); end
    s = 4'b0000; r = 4'b0000; clr_err = 1'b1;
    step();
    tests_run++;
    if (err_cnt !== 3'd0) begin tests_failed++; $display("FAIL clr_cnt: got %0d want 0", err_cnt); end
    tests_run++;
    if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL clr_sticky: got %b want 0", err_sticky); end
    s = 4'b0100; r = 4'b0100;
    step();
    clr_err = 1'b0; s = 4'b0000; r = 4'b0000;
    tests_run++;
    if (err_cnt !== 3'd1) begin tests_failed++; $display("FAIL clr_ev_cnt: got %0d want 1", err_cnt); end
    tests_run++;
    if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL clr_ev_sticky: got %b want 1", err_sticky); end
    tests_run++;
    if (conflict !== 4'b0100) begin tests_failed++; $display("FAIL clr_ev_conflict: got %b want 0100", conflict); end
  endtask

  task automatic test_mid_reset();
    // Q is 0011 here; run toggle mode on all channels.
    en = 1'b1; mode = 2'b11; s = 4'b1111; r = 4'b1111; clr_err = 1'b0;
    step();
    tests_run++;
    if (q !== 4'b1100) begin tests_failed++; $display("FAIL mid_toggle1: got %b want 1100", q); end
    step();
    tests_run++;
    if (q !== 4'b0011) begin tests_failed++; $display("FAIL mid_toggle2: got %b want 0011", q); end
    rst = 1'b1; clr_err = 1'b1;
    step();
    rst = 1'b0; clr_err = 1'b0;
    tests_run++;
    if (q !== 4'b1010 || qn !== 4'b0101) begin
      tests_failed++; $display("FAIL mid_rst_q: got q=%b qn=%b want q=1010 qn=0101", q, qn);
    end
    tests_run++;
    if (err_cnt !== 3'd0 || err_sticky !== 1'b0 || conflict !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_rst_err: got cnt=%0d sticky=%b conf=%b want 0/0/0000", err_cnt, err_sticky, conflict);
    end
    step();
    tests_run++;
    if (q !== 4'b0101 || qn !== 4'b1010) begin
      tests_failed++; $display("FAIL mid_resume_q: got q=%b qn=%b want q=0101 qn=1010", q, qn);
    end
    tests_run++;
    if (err_cnt !== 3'd1 || err_sticky !== 1'b1 || conflict !== 4'b1111) begin
      tests_failed++; $display("FAIL mid_resume_err: got cnt=%0d sticky=%b conf=%b want 1/1/1111", err_cnt, err_sticky, conflict);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; s = '0; r = '0; clr_err = 1'b0;
    test_reset();
    test_basic();
    test_mode_sweep();
    test_enable_gating();
    test_saturation();
    test_clear_collision();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
